// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage LEGv8 pipeline (EX/MEM/WB scoreboard).
// Optional macro PIPE_FLAG_FWD_EN: B.cond takes live EX ALU flags instead of stalling.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_r2,
    input  logic             id_use_rn,
    input  logic             id_use_r2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_flagen,
    input  logic             id_is_cbz,
    input  logic             id_is_bcond,
    input  logic             id_br_taken,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_flags
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] r2;
        logic             use_rn;
        logic             use_r2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic             flagen;
    } slot_t;

    slot_t ex_q, mem_q, wb_q, id_slot;
    logic  load_use, cbz_stall, bcond_hit, stall;

    function automatic logic eff_write(input slot_t s);
        return s.valid && s.regwrite && (s.rd != ZR);
    endfunction

    // A load sitting in MEM cannot forward its ALU address; it is picked up from WB instead.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input slot_t m, input slot_t w);
        if (eff_write(m) && m.rd == src && !m.memread)
            return 2'b01;
        else if (eff_write(w) && w.rd == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign id_slot = {id_valid, id_rn, id_r2, id_use_rn, id_use_r2, id_rd,
                      id_regwrite, id_memread, id_flagen};

    always_comb begin
        load_use  = id_valid && ex_q.valid && ex_q.memread && eff_write(ex_q) &&
                    ((id_use_rn && id_rn == ex_q.rd) || (id_use_r2 && id_r2 == ex_q.rd));
        cbz_stall = id_valid && id_is_cbz &&
                    ((eff_write(ex_q) && ex_q.rd == id_r2) || (eff_write(mem_q) && mem_q.rd == id_r2));
        bcond_hit = id_valid && id_is_bcond && ex_q.valid && ex_q.flagen;
`ifdef PIPE_FLAG_FWD_EN
        stall     = load_use || cbz_stall;
`else
        stall     = load_use || cbz_stall || bcond_hit;
`endif
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        fwd_flags   = 1'b0;
        if (!reset) begin
            fwd_a = fwd_sel(ex_q.rn, mem_q, wb_q);
            fwd_b = fwd_sel(ex_q.r2, mem_q, wb_q);
`ifdef PIPE_FLAG_FWD_EN
            fwd_flags = bcond_hit;
`endif
            if (mem_busy) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
            end else begin
                stall_pc    = stall;
                stall_ifid  = stall;
                bubble_idex = stall;
                flush_ifid  = id_valid && id_br_taken && !stall;
            end
        end
    end

    // Bubbles are loaded as an all-zero slot so no stale fields linger in EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (stall || !id_valid) ? '0 : id_slot;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus randomized
// instruction streams checked against a slot-list reference model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       id_valid, id_use_rn, id_use_r2, id_regwrite, id_memread, id_flagen;
    logic       id_is_cbz, id_is_bcond, id_br_taken, mem_busy;
    logic [4:0] id_rn, id_r2, id_rd;
    logic       stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_flags;
    logic [1:0] fwd_a, fwd_b;

    pipeline_hazard_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_r2(id_r2),
        .id_use_rn(id_use_rn), .id_use_r2(id_use_r2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_flagen(id_flagen),
        .id_is_cbz(id_is_cbz), .id_is_bcond(id_is_bcond), .id_br_taken(id_br_taken),
        .mem_busy(mem_busy), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_flags(fwd_flags)
    );

    typedef struct packed {
        logic valid; logic [4:0] rn; logic [4:0] r2; logic use_rn; logic use_r2;
        logic [4:0] rd; logic regwrite; logic memread; logic flagen;
        logic cbz; logic bcond; logic taken;
    } instr_t;

    typedef struct packed {
        logic valid; logic [4:0] rn; logic [4:0] r2; logic use_rn; logic use_r2;
        logic [4:0] rd; logic regwrite; logic memread; logic flagen;
    } slot_t;

    // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
    slot_t sb [3];
    int    tests_run = 0;
    int    tests_failed = 0;
    localparam instr_t NOP = '0;

    function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] r2,
                                  input logic use_rn, input logic use_r2, input logic regwrite,
                                  input logic memread, input logic flagen, input logic cbz,
                                  input logic bcond, input logic taken);
        return {1'b1, rn, r2, use_rn, use_r2, rd, regwrite, memread, flagen, cbz, bcond, taken};
    endfunction

    function automatic logic writes(input slot_t s);
        return s.valid && s.regwrite && s.rd != 5'd31;
    endfunction

    function automatic logic [1:0] src_sel(input logic [4:0] r);
        if (writes(sb[1]) && sb[1].rd == r && !sb[1].memread) return 2'b01;
        if (writes(sb[2]) && sb[2].rd == r) return 2'b10;
        return 2'b00;
    endfunction

    // Expected {stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_a, fwd_b, fwd_flags}.
    function automatic logic [8:0] model_out(input instr_t i, input logic busy);
        logic lu, cb, bc, st, ff;
        lu = i.valid && sb[0].valid && sb[0].memread && writes(sb[0]) &&
             ((i.use_rn && i.rn == sb[0].rd) || (i.use_r2 && i.r2 == sb[0].rd));
        cb = i.valid && i.cbz && ((writes(sb[0]) && sb[0].rd == i.r2) ||
                                  (writes(sb[1]) && sb[1].rd == i.r2));
        bc = i.valid && i.bcond && sb[0].valid && sb[0].flagen;
`ifdef PIPE_FLAG_FWD_EN
        st = lu || cb;
        ff = bc;
`else
        st = lu || cb || bc;
        ff = 1'b0;
`endif
        if (busy) return {1'b1, 1'b1, 1'b0, 1'b0, src_sel(sb[0].rn), src_sel(sb[0].r2), ff};
        return {st, st, st, i.valid && i.taken && !st, src_sel(sb[0].rn), src_sel(sb[0].r2), ff};
    endfunction

    task automatic cycle(input instr_t i, input logic busy, input logic rst,
                         output logic [8:0] obs, output logic [8:0] exp);
        reset = rst;
        id_valid = i.valid; id_rn = i.rn; id_r2 = i.r2; id_use_rn = i.use_rn;
        id_use_r2 = i.use_r2; id_rd = i.rd; id_regwrite = i.regwrite;
        id_memread = i.memread; id_flagen = i.flagen; id_is_cbz = i.cbz;
        id_is_bcond = i.bcond; id_br_taken = i.taken; mem_busy = busy;
        @(negedge clk);
        exp = rst ? 9'd0 : model_out(i, busy);
        obs = {stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_a, fwd_b, fwd_flags};
        if (rst) begin
            for (int k = 0; k < 3; k++) sb[k] = '0;
        end else if (!busy) begin
            sb[2] = sb[1];
            sb[1] = sb[0];
            if (exp[6] || !i.valid) sb[0] = '0;
            else sb[0] = {i.valid, i.rn, i.r2, i.use_rn, i.use_r2, i.rd, i.regwrite, i.memread, i.flagen};
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 5'd31 : 5'(v);
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind = $urandom_range(0, 4);
        i = mk(pick_reg(), pick_reg(), pick_reg(), 1'b1, 1'($urandom_range(0, 1)), 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        case (kind)
            1: begin i.memread = 1'b1; i.use_r2 = 1'b0; end
            2: begin i.cbz = 1'b1; i.regwrite = 1'b0; i.use_rn = 1'b0; i.use_r2 = 1'b1; end
            3: begin i.bcond = 1'b1; i.regwrite = 1'b0; i.use_rn = 1'b0; i.use_r2 = 1'b0; end
            4: i.flagen = 1'b1;
            default: ;
        endcase
        if (kind < 2 || kind == 4) i.taken = 1'b0;
        i.valid = ($urandom_range(0, 7) != 0);
        return i;
    endfunction

    task automatic test_reset();
        logic [8:0] o, e;
        for (int n = 0; n < 3; n++) begin
            cycle(rand_instr(), 1'($urandom_range(0, 1)), 1'b1, o, e);
            tests_run++;
            if (o !== 9'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs: got %b want %b", o, 9'd0);
            end
        end
        cycle(NOP, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got %b want %b", o, 9'd0);
        end
    endtask

    task automatic test_alu_fwd();
        logic [8:0] o, e;
        cycle(NOP, 1'b0, 1'b1, o, e);
        cycle(mk(1, 4, 5, 1, 1, 1, 0, 1, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(mk(2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'd0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL alu_no_stall: got %b want %b", o, 9'd0);
        end
        cycle(NOP, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'b0000_01_00_0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL alu_fwd_a01: got %b want %b", o, 9'b0000_01_00_0);
        end
    endtask

    task automatic test_load_use();
        logic [8:0] o, e;
        instr_t add;
        add = mk(2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        cycle(NOP, 1'b0, 1'b1, o, e);
        cycle(mk(1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(add, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'b111_0_00_00_0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL load_use_stall: got %b want %b", o, 9'b111000000);
        end
        cycle(add, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'd0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL load_use_single: got %b want %b", o, 9'd0);
        end
        cycle(NOP, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'b0000_10_10_0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL load_use_fwd10: got %b want %b", o, 9'b000010100);
        end
    endtask

    task automatic test_cbz();
        logic [8:0] o, e;
        instr_t cbz;
        cbz = mk(0, 0, 4, 0, 1, 0, 0, 0, 1, 0, 1);
        cycle(NOP, 1'b0, 1'b1, o, e);
        cycle(mk(4, 5, 6, 1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        for (int n = 0; n < 2; n++) begin
            cycle(cbz, 1'b0, 1'b0, o, e);
            tests_run++;
            if (o !== 9'b111_0_00_00_0 || o !== e) begin
                tests_failed++;
                $display("[TB] FAIL cbz_stall%0d: got %b want %b", n, o, 9'b111000000);
            end
        end
        cycle(cbz, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'b000_1_00_00_0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL cbz_flush: got %b want %b", o, 9'b000100000);
        end
        cycle(NOP, 1'b0, 1'b1, o, e);
        cycle(mk(31, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(mk(3, 31, 31, 1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(mk(0, 0, 31, 0, 1, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'd0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL xzr_no_hazard: got %b want %b", o, 9'd0);
        end
    endtask

    task automatic test_bcond();
        logic [8:0] o, e, want;
`ifdef PIPE_FLAG_FWD_EN
        want = 9'b000_0_00_00_1;
`else
        want = 9'b111_0_00_00_0;
`endif
        cycle(NOP, 1'b0, 1'b1, o, e);
        cycle(mk(5, 1, 2, 1, 1, 1, 0, 1, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== want || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL bcond_flags: got %b want %b", o, want);
        end
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL bcond_after: got %b want %b", o, e);
        end
    endtask

    task automatic test_freeze();
        logic [8:0] o, e;
        instr_t add;
        add = mk(2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1);
        cycle(NOP, 1'b0, 1'b1, o, e);
        cycle(mk(1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        for (int n = 0; n < 3; n++) begin
            cycle(add, 1'b1, 1'b0, o, e);
            tests_run++;
            if (o !== 9'b110_0_00_00_0 || o !== e) begin
                tests_failed++;
                $display("[TB] FAIL freeze%0d: got %b want %b", n, o, 9'b110000000);
            end
        end
        cycle(add, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'b111_0_00_00_0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL freeze_release_bubble: got %b want %b", o, 9'b111000000);
        end
        cycle(add, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'b000_1_00_00_0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL freeze_resume: got %b want %b", o, 9'b000100000);
        end
    endtask

    task automatic test_reset_midstream();
        logic [8:0] o, e;
        instr_t rdr;
        rdr = mk(4, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0);
        cycle(NOP, 1'b0, 1'b1, o, e);
        cycle(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(mk(3, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(mk(2, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0), 1'b0, 1'b0, o, e);
        cycle(rdr, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL midstream_stall: got %b want %b", o, e);
        end
        cycle(rdr, 1'b1, 1'b1, o, e);
        tests_run++;
        if (o !== 9'd0) begin
            tests_failed++;
            $display("[TB] FAIL midstream_reset: got %b want %b", o, 9'd0);
        end
        cycle(rdr, 1'b0, 1'b0, o, e);
        tests_run++;
        if (o !== 9'd0 || o !== e) begin
            tests_failed++;
            $display("[TB] FAIL midstream_cleared: got %b want %b", o, 9'd0);
        end
    endtask

    task automatic test_random();
        logic [8:0] o, e;
        instr_t cur;
        cycle(NOP, 1'b0, 1'b1, o, e);
        cur = rand_instr();
        for (int n = 0; n < 600; n++) begin
            logic busy, rst;
            busy = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 59) == 0);
            cycle(cur, busy, rst, o, e);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle%0d: got %b want %b", n, o, e);
            end
            if (rst || (!busy && !e[6])) cur = rand_instr();
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) sb[k] = '0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_cbz();
        test_bcond();
        test_freeze();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
